serial_carry_adder16: RTL
=========================

Name: serial_carry_adder16

Overview:
- Bit-serial, multi-cycle adder. It is the addition-direction counterpart of the 16-bit ripple-borrow subtractor in the lab3 datapath.
- Resolves one bit per clock, LSB first, through a single carry flip-flop. This replaces a 16-deep combinational carry chain.
- Used where area matters more than latency. It is driven by a start/done handshake from the lab controller.

Parameters:
WIDTH, 16, operand and sum width in bits (>=2)

Ports:
clk  input  1  rising-edge clock, the block's only clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when idle
A  input  WIDTH  augend; captured on the accepting edge
B  input  WIDTH  addend; captured on the accepting edge
Cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when S/Cout hold a new result
S  output  WIDTH  sum, registered
Cout  output  1  carry-out of bit WIDTH-1, registered

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Asserting rst_n low immediately forces all state and outputs to zero: busy=0, done=0, S=0, Cout=0, state=IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge latches A and B into operand shift registers and Cin into the carry FF.
  - Bit counter cleared to 0; next state RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - sum_bit = a0 ^ b0 ^ c; carry_next = majority(a0, b0, c).
  - sum_bit is shifted into the MSB of the internal sum register; both operand registers shift right by 1; counter increments.
  - When counter reaches WIDTH-1, this edge processes the last bit and the next state is DONE.
- DONE, for exactly one cycle:
  - done=1; S and Cout are loaded from the internal sum register and carry FF on the transition into DONE.
  - If start=1: re-accept immediately (same capture as IDLE), next state RUN.
  - Otherwise: next state IDLE.
- busy = (state == RUN).
- Latency: start accepted at edge 0 → done high in the cycle following edge WIDTH. One result per WIDTH+1 cycles; back-to-back operation through DONE gives a result every WIDTH+1 cycles.
- S/Cout hold their last value until the next completion; they never show partial sums.
- start during RUN is ignored, with no queuing. A/B/Cin may change freely after acceptance.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1); unsigned.
- Reset mid-RUN aborts the operation: no done pulse, S/Cout return to 0.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port V (1 bit, reset 0), the signed two's-complement overflow flag.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - V is captured alongside S/Cout and held the same way.
- Undefined: port V absent, no overflow logic synthesized. All other behaviour is identical.

Test Plan:
- Basic add: A=0x1234, B=0x4321, Cin=0, start 1 cycle → busy high 16 cycles, then done pulse; S=0x5555, Cout=0.
- Full carry ripple: A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1. Then A=0xFFFF, B=0xFFFF, Cin=1 → S=0xFFFF, Cout=1.
- start held during RUN, with A/B changed mid-run → ignored; result is that of the first accepted operands; exactly one done pulse.
- Back-to-back: start=1 in the DONE cycle with A=0x0003, B=0x0004 → next done 17 cycles later with S=0x0007; the prior result holds until then.
- Reset mid-op: rst_n low at cycle 8 of RUN → busy, done, S, Cout go to 0 immediately with no done pulse. A new start after release produces the correct sum.
- With SERIAL_ADD_OVF_EN:
  - A=0x7FFF, B=0x0001 → S=0x8000, V=1, Cout=0.
  - A=0x8000, B=0x8000 → S=0x0000, V=1, Cout=1.
  - A=0x0001, B=0x0001 → V=0.

Source files
------------

// File: rtl/serial_carry_adder16.sv
// Bit-serial adder: one sum bit per clock, LSB first, through a single carry flip-flop.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output V.
module serial_carry_adder16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [WIDTH-1:0] sumSh_q, sumSh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sOut_q, sOut_d;
   logic             cout_q, cout_d;
   logic             sumBit;
   logic             carryNext;
`ifdef SERIAL_ADD_OVF_EN
   logic             v_q, v_d;
`endif

   assign sumBit    = aSh_q[0] ^ bSh_q[0] ^ carry_q;
   assign carryNext = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aSh_q   <= '0;
         bSh_q   <= '0;
         sumSh_q <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sOut_q  <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         aSh_q   <= aSh_d;
         bSh_q   <= bSh_d;
         sumSh_q <= sumSh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sOut_q  <= sOut_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         v_q     <= v_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      aSh_d   = aSh_q;
      bSh_d   = bSh_q;
      sumSh_d = sumSh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sOut_d  = sOut_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      v_d     = v_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               aSh_d   = A;
               bSh_d   = B;
               carry_d = Cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            aSh_d   = aSh_q >> 1;
            bSh_d   = bSh_q >> 1;
            sumSh_d = {sumBit, sumSh_q[WIDTH-1:1]};
            carry_d = carryNext;
            cnt_d   = cnt_q + CW'(1);
            // Last bit: publish the completed sum so S never shows a partial value.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               sOut_d  = {sumBit, sumSh_q[WIDTH-1:1]};
               cout_d  = carryNext;
`ifdef SERIAL_ADD_OVF_EN
               v_d     = carry_q ^ carryNext;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign S    = sOut_q;
   assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign V    = v_q;
`endif

endmodule
